// File: rtl/div_rem_unit_pkg.sv
// Shared constants for the iterative divide/remainder unit: operation and
// state encodings plus small operand helpers used by the top level.
package div_rem_unit_pkg;

   localparam int DIV_WIDTH = 32;

   // funct3[1:0] encodings of the M-extension divide family
   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } divOpE;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10,
      ST_DONE = 2'b11
   } divStateE;

   // Magnitude of a two's-complement value (0x80000000 maps to itself).
   function automatic logic [DIV_WIDTH-1:0] absVal(input logic [DIV_WIDTH-1:0] value);
      logic [DIV_WIDTH-1:0] res;
      if (value[DIV_WIDTH-1]) begin
         res = {DIV_WIDTH{1'b0}} - value;
      end else begin
         res = value;
      end
      return res;
   endfunction

   function automatic logic opIsSigned(input logic [1:0] op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic opIsRem(input logic [1:0] op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/div_rem_step.sv
// One restoring shift-subtract iteration. The dividend is shifted out of the
// top of the quotient register while quotient bits are shifted in at the bottom.
module div_rem_step
   import div_rem_unit_pkg::*;
(
   input  logic [DIV_WIDTH:0]   iPartRem,
   input  logic [DIV_WIDTH-1:0] iQuot,
   input  logic [DIV_WIDTH-1:0] iDivisor,
   output logic [DIV_WIDTH:0]   oPartRem,
   output logic [DIV_WIDTH-1:0] oQuot
);

   logic [DIV_WIDTH:0] shiftedS;
   logic [DIV_WIDTH:0] diffS;
   logic               unusedTopBitS;

   // The partial remainder is always below the divisor, so its top bit is
   // zero on entry and only the shifted-out carry position needs the 33rd bit.
   assign unusedTopBitS = iPartRem[DIV_WIDTH];

   // Shift in the next dividend bit, trial-subtract, keep or restore.
   always_comb begin
      shiftedS = {iPartRem[DIV_WIDTH-1:0], iQuot[DIV_WIDTH-1]};
      diffS    = shiftedS - {1'b0, iDivisor};
      if (!diffS[DIV_WIDTH]) begin
         oPartRem = diffS;
         oQuot    = {iQuot[DIV_WIDTH-2:0], 1'b1};
      end else begin
         oPartRem = shiftedS;
         oQuot    = {iQuot[DIV_WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_rem_unit.sv
// Multi-cycle DIV/DIVU/REM/REMU unit for the EX stage. Works on magnitudes
// with a restoring divider, fixes signs afterwards, and short-circuits the
// divide-by-zero and signed-overflow cases to a one-cycle result.
module div_rem_unit
   import div_rem_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iStart,
   input  logic [1:0]       iOp,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   input  logic             iFlush,
   output logic             oStallReq,
   output logic             oValid,
   output logic [WIDTH-1:0] oResult
);

   divStateE         stateR;
   logic [4:0]       cntR;
   logic [1:0]       opR;
   logic             negateR;
   logic [WIDTH-1:0] divisorR;
   logic [WIDTH-1:0] quotR;
   logic [WIDTH:0]   partRemR;
   logic [WIDTH-1:0] resultR;
   logic             validR;

   logic [WIDTH:0]   nextRemS;
   logic [WIDTH-1:0] nextQuotS;

   logic             signedS;
   logic             remS;
   logic [WIDTH-1:0] absAS;
   logic [WIDTH-1:0] absBS;
   logic             divZeroS;
   logic             overflowS;
   logic             negS;
   logic [WIDTH-1:0] specialResS;
   logic [WIDTH-1:0] fixValS;
   logic [WIDTH-1:0] finalS;

   div_rem_step uStep (
      .iPartRem (partRemR),
      .iQuot    (quotR),
      .iDivisor (divisorR),
      .oPartRem (nextRemS),
      .oQuot    (nextQuotS)
   );

   // Decode the incoming operation: magnitudes, result sign, bypass cases.
   always_comb begin
      signedS   = opIsSigned(iOp);
      remS      = opIsRem(iOp);
      divZeroS  = (iB == {WIDTH{1'b0}});
      overflowS = signedS && (iA == 32'h8000_0000) && (iB == 32'hFFFF_FFFF);
      if (signedS) begin
         absAS = absVal(iA);
         absBS = absVal(iB);
         if (remS) begin
            negS = iA[WIDTH-1];
         end else begin
            negS = iA[WIDTH-1] ^ iB[WIDTH-1];
         end
      end else begin
         absAS = iA;
         absBS = iB;
         negS  = 1'b0;
      end
      if (divZeroS) begin
         if (remS) begin
            specialResS = iA;
         end else begin
            specialResS = 32'hFFFF_FFFF;
         end
      end else if (overflowS) begin
         if (remS) begin
            specialResS = 32'h0000_0000;
         end else begin
            specialResS = 32'h8000_0000;
         end
      end else begin
         specialResS = 32'h0000_0000;
      end
   end

   // Select quotient or remainder and apply the deferred sign correction.
   always_comb begin
      if (opIsRem(opR)) begin
         fixValS = partRemR[WIDTH-1:0];
      end else begin
         fixValS = quotR;
      end
      if (negateR) begin
         finalS = {WIDTH{1'b0}} - fixValS;
      end else begin
         finalS = fixValS;
      end
   end

   // Pipeline stall: asserted from the accept cycle until the result is ready.
   always_comb begin
      oStallReq = 1'b0;
      if (iRST) begin
         oStallReq = 1'b0;
      end else begin
         case (stateR)
            ST_IDLE: oStallReq = iStart & ~iFlush;
            ST_CALC: oStallReq = 1'b1;
            ST_FIX:  oStallReq = 1'b1;
            ST_DONE: oStallReq = 1'b0;
            default: oStallReq = 1'b0;
         endcase
      end
   end

   // Controller and datapath registers.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         stateR   <= ST_IDLE;
         cntR     <= 5'd0;
         opR      <= 2'b00;
         negateR  <= 1'b0;
         divisorR <= {WIDTH{1'b0}};
         quotR    <= {WIDTH{1'b0}};
         partRemR <= {(WIDTH+1){1'b0}};
         resultR  <= {WIDTH{1'b0}};
         validR   <= 1'b0;
      end else if (iFlush) begin
         stateR <= ST_IDLE;
         validR <= 1'b0;
      end else begin
         case (stateR)
            ST_IDLE: begin
               validR <= 1'b0;
               if (iStart) begin
                  opR      <= iOp;
                  negateR  <= negS;
                  divisorR <= absBS;
                  quotR    <= absAS;
                  partRemR <= {(WIDTH+1){1'b0}};
                  if (divZeroS || overflowS) begin
                     resultR <= specialResS;
                     validR  <= 1'b1;
                     stateR  <= ST_DONE;
                  end else begin
                     cntR   <= 5'd31;
                     stateR <= ST_CALC;
                  end
               end else begin
                  stateR <= ST_IDLE;
               end
            end
            ST_CALC: begin
               partRemR <= nextRemS;
               quotR    <= nextQuotS;
               cntR     <= cntR - 5'd1;
               if (cntR == 5'd0) begin
                  stateR <= ST_FIX;
               end else begin
                  stateR <= ST_CALC;
               end
            end
            ST_FIX: begin
               resultR <= finalS;
               validR  <= 1'b1;
               stateR  <= ST_DONE;
            end
            ST_DONE: begin
               validR <= 1'b0;
               stateR <= ST_IDLE;
            end
            default: begin
               validR <= 1'b0;
               stateR <= ST_IDLE;
            end
         endcase
      end
   end

   assign oValid  = validR;
   assign oResult = resultR;

endmodule
